// File: rtl/dmem_mover_pkg.sv
// Shared types and constants for the data-memory block mover.
//   mover_state_t : copy engine FSM state
//   DIR_FWD/BWD   : copy direction, latched when a copy starts
package dmem_mover_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        FIN
    } mover_state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_BWD = 1'b1;

endpackage

// File: rtl/dmem_block_mover.sv
// Block-copy (memmove) engine sitting in front of a single-port data memory.
// Muxes CPU load/store traffic with its own read/write copy traffic onto the
// one memory port, and stalls the CPU while a copy is in flight.
//
// Ports:
//   Clk, Reset                    clock, asynchronous active-low reset
//   Start, SrcAddr, DstAddr, Len  copy request (sampled only when idle)
//   Busy, Done                    engine status; Done is a 1-cycle pulse
//   CpuWriteEn, CpuAddr, CpuDataIn CPU load/store request
//   CpuDataOut, CpuStall          CPU read data and stall
//   MemWriteEn, MemAddr, MemDataIn memory port drive
//   MemDataOut                    combinational memory read data
module dmem_block_mover
    import dmem_mover_pkg::*;
#(
    parameter int unsigned W = 8,
    parameter int unsigned A = 8
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A:0]   Len,
    output logic         Busy,
    output logic         Done,
    input  logic         CpuWriteEn,
    input  logic [A-1:0] CpuAddr,
    input  logic [W-1:0] CpuDataIn,
    output logic [W-1:0] CpuDataOut,
    output logic         CpuStall,
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddr,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    localparam logic [A:0]   LEN_MAX = {1'b1, {A{1'b0}}};
    localparam logic [A:0]   CNT_ONE = {{A{1'b0}}, 1'b1};
    localparam logic [A-1:0] PTR_ONE = {{(A-1){1'b0}}, 1'b1};

    mover_state_t state_q, state_d;
    logic         dir_q, dir_d;
    logic [A-1:0] src_ptr_q, src_ptr_d;
    logic [A-1:0] dst_ptr_q, dst_ptr_d;
    logic [A:0]   cnt_q, cnt_d;
    logic [W-1:0] hold_q, hold_d;

    logic [A:0]   len_c;
    logic [A-1:0] addr_diff;
    logic         start_bwd;
    logic [A-1:0] len_m1;

    // Request decode: clamp the length and pick the overlap-safe direction.
    always_comb begin
        len_c     = (Len > LEN_MAX) ? LEN_MAX : Len;
        addr_diff = DstAddr - SrcAddr;
        // Destination starts inside the source range: copy top-down.
        start_bwd = ({1'b0, addr_diff} < len_c);
        // Len == 2**A truncates to 0 here, and 0 - 1 wraps to the last byte.
        len_m1    = len_c[A-1:0] - PTR_ONE;
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    if (len_c == '0 || SrcAddr == DstAddr) begin
                        state_d = FIN;
                    end else begin
                        state_d   = RD;
                        dir_d     = start_bwd ? DIR_BWD : DIR_FWD;
                        src_ptr_d = start_bwd ? SrcAddr + len_m1 : SrcAddr;
                        dst_ptr_d = start_bwd ? DstAddr + len_m1 : DstAddr;
                        cnt_d     = len_c;
                    end
                end
            end
            RD: begin
                hold_d  = MemDataOut;
                state_d = WR;
            end
            WR: begin
                src_ptr_d = (dir_q == DIR_BWD) ? src_ptr_q - PTR_ONE : src_ptr_q + PTR_ONE;
                dst_ptr_d = (dir_q == DIR_BWD) ? dst_ptr_q - PTR_ONE : dst_ptr_q + PTR_ONE;
                cnt_d     = cnt_q - CNT_ONE;
                state_d   = (cnt_q == CNT_ONE) ? FIN : RD;
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            dir_q     <= DIR_FWD;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            cnt_q     <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            cnt_q     <= cnt_d;
            hold_q    <= hold_d;
        end
    end

    // Memory port mux: CPU owns the port only while idle.
    always_comb begin
        MemWriteEn = 1'b0;
        MemAddr    = CpuAddr;
        MemDataIn  = hold_q;
        unique case (state_q)
            IDLE: begin
                MemWriteEn = CpuWriteEn;
                MemAddr    = CpuAddr;
                MemDataIn  = CpuDataIn;
            end
            RD: begin
                MemAddr = src_ptr_q;
            end
            WR: begin
                MemWriteEn = 1'b1;
                MemAddr    = dst_ptr_q;
            end
            FIN: begin
                MemWriteEn = 1'b0;
            end
            default: begin
                MemWriteEn = 1'b0;
            end
        endcase
    end

    always_comb begin
        Busy       = (state_q != IDLE);
        Done       = (state_q == FIN);
        CpuStall   = Busy;
        CpuDataOut = MemDataOut;
    end

endmodule

// File: tb/tb_dmem_block_mover.sv
// Bench for dmem_block_mover: DUT plus a behavioural data memory.
// Fixed vectors, hand-written corner sequences and random copies checked
// against a memmove reference model.
module tb_dmem_block_mover;

    logic       Clk;
    logic       Reset;
    logic       Start;
    logic [7:0] SrcAddr;
    logic [7:0] DstAddr;
    logic [8:0] Len;
    logic       Busy;
    logic       Done;
    logic       CpuWriteEn;
    logic [7:0] CpuAddr;
    logic [7:0] CpuDataIn;
    logic [7:0] CpuDataOut;
    logic       CpuStall;
    logic       MemWriteEn;
    logic [7:0] MemAddr;
    logic [7:0] MemDataIn;
    logic [7:0] MemDataOut;

    dmem_block_mover #(.W(8), .A(8)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .SrcAddr    (SrcAddr),
        .DstAddr    (DstAddr),
        .Len        (Len),
        .Busy       (Busy),
        .Done       (Done),
        .CpuWriteEn (CpuWriteEn),
        .CpuAddr    (CpuAddr),
        .CpuDataIn  (CpuDataIn),
        .CpuDataOut (CpuDataOut),
        .CpuStall   (CpuStall),
        .MemWriteEn (MemWriteEn),
        .MemAddr    (MemAddr),
        .MemDataIn  (MemDataIn),
        .MemDataOut (MemDataOut)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Data memory: combinational read, posedge write, bulk load on request.
    logic [7:0] mem      [256];
    logic [7:0] load_img [256];
    logic [7:0] exp_mem  [256];
    logic       load_req;

    assign MemDataOut = mem[MemAddr];

    always @(posedge Clk) begin
        if (load_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= load_img[i];
        end else if (MemWriteEn) begin
            mem[MemAddr] <= MemDataIn;
        end
    end

    int checks;
    int failures;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic load_mem(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            load_img[i] = rnd ? 8'($urandom) : 8'(i);
            exp_mem[i]  = load_img[i];
        end
        @(negedge Clk);
        load_req = 1'b1;
        @(negedge Clk);
        load_req = 1'b0;
    endtask

    // Reference: memmove semantics, every destination byte gets the original source byte.
    task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
        logic [7:0] snap [256];
        for (int i = 0; i < 256; i++) snap[i] = exp_mem[i];
        for (int i = 0; i < n; i++) exp_mem[8'(d + i)] = snap[8'(s + i)];
    endtask

    task automatic check_mem(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
        check(name, bad, 0);
    endtask

    task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [8:0] l,
                           output int busy_n, output int done_n, output int we_n,
                           output int stall_bad);
        @(negedge Clk);
        Start   = 1'b1;
        SrcAddr = s;
        DstAddr = d;
        Len     = l;
        @(negedge Clk);
        Start     = 1'b0;
        busy_n    = 0;
        done_n    = 0;
        we_n      = 0;
        stall_bad = 0;
        while (Busy && busy_n < 2000) begin
            busy_n++;
            if (Done) done_n++;
            if (MemWriteEn) we_n++;
            if (CpuStall !== Busy) stall_bad++;
            @(negedge Clk);
        end
        if (busy_n >= 2000) begin
            failures++;
            $display("FAIL copy_timeout: got busy>=%0d expected idle", busy_n);
        end
    endtask

    typedef struct {
        logic [7:0]      src;
        logic [7:0]      dst;
        logic [8:0]      len;
        int              exp_busy;
        int              exp_we;
        logic [7:0]      chk_addr;
        int              chk_n;
        logic [3:0][7:0] chk_val;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int busy_n, done_n, we_n, stall_bad;
        int n;
        logic [7:0] s, d;

        checks     = 0;
        failures   = 0;
        load_req   = 1'b0;
        Reset      = 1'b0;
        Start      = 1'b0;
        SrcAddr    = '0;
        DstAddr    = '0;
        Len        = '0;
        CpuWriteEn = 1'b0;
        CpuAddr    = 8'h33;
        CpuDataIn  = '0;

        vecs[0] = '{8'h10, 8'h40, 9'd4, 9, 4, 8'h40, 4, {8'h13, 8'h12, 8'h11, 8'h10}};
        vecs[1] = '{8'h20, 8'h22, 9'd4, 9, 4, 8'h22, 4, {8'h23, 8'h22, 8'h21, 8'h20}};
        vecs[2] = '{8'h22, 8'h20, 9'd4, 9, 4, 8'h20, 4, {8'h25, 8'h24, 8'h23, 8'h22}};
        vecs[3] = '{8'hFE, 8'h01, 9'd3, 7, 3, 8'h01, 3, {8'h00, 8'h00, 8'hFF, 8'hFE}};
        vecs[4] = '{8'h30, 8'h50, 9'd0, 1, 0, 8'h50, 1, {8'h00, 8'h00, 8'h00, 8'h50}};
        vecs[5] = '{8'h33, 8'h33, 9'd5, 1, 0, 8'h33, 1, {8'h00, 8'h00, 8'h00, 8'h33}};

        // Reset state and CPU pass-through.
        repeat (2) @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_done", Done, 0);
        check("rst_stall", CpuStall, 0);
        CpuWriteEn = 1'b1;
        CpuAddr    = 8'h5C;
        CpuDataIn  = 8'hC3;
        #1;
        check("rst_pass_we", MemWriteEn, 1);
        check("rst_pass_addr", MemAddr, 8'h5C);
        check("rst_pass_data", MemDataIn, 8'hC3);
        CpuWriteEn = 1'b0;
        CpuAddr    = 8'h33;
        @(negedge Clk);
        Reset = 1'b1;

        load_mem(1'b0);
        #1;
        check("idle_cpu_read", CpuDataOut, 8'h33);

        // Fixed vectors.
        foreach (vecs[k]) begin
            load_mem(1'b0);
            do_copy(vecs[k].src, vecs[k].dst, vecs[k].len, busy_n, done_n, we_n, stall_bad);
            model_copy(vecs[k].src, vecs[k].dst, 32'(vecs[k].len));
            check($sformatf("vec%0d_busy", k), busy_n, vecs[k].exp_busy);
            check($sformatf("vec%0d_done", k), done_n, 1);
            check($sformatf("vec%0d_we", k), we_n, vecs[k].exp_we);
            check($sformatf("vec%0d_stall", k), stall_bad, 0);
            for (int j = 0; j < vecs[k].chk_n; j++)
                check($sformatf("vec%0d_byte%0d", k, j), mem[8'(vecs[k].chk_addr + j)],
                      vecs[k].chk_val[j]);
            check_mem($sformatf("vec%0d_mem", k));
        end

        // Over-range length clamps to a full-memory copy.
        load_mem(1'b0);
        do_copy(8'h00, 8'h80, 9'h1FF, busy_n, done_n, we_n, stall_bad);
        check("clamp_busy", busy_n, 513);
        check("clamp_done", done_n, 1);
        check("clamp_we", we_n, 256);

        // CPU store in the Start cycle lands; a held CPU store is ignored while busy.
        load_mem(1'b0);
        CpuWriteEn = 1'b1;
        CpuAddr    = 8'h80;
        CpuDataIn  = 8'hA5;
        do_copy(8'h10, 8'h40, 9'd4, busy_n, done_n, we_n, stall_bad);
        CpuWriteEn = 1'b0;
        check("cpu_start_store", mem[8'h80], 8'hA5);
        check("cpu_busy_we", we_n, 4);
        check("cpu_copy_byte", mem[8'h43], 8'h13);

        // Start raised mid-copy is neither taken nor queued.
        load_mem(1'b0);
        @(negedge Clk);
        Start   = 1'b1;
        SrcAddr = 8'h10;
        DstAddr = 8'h60;
        Len     = 9'd2;
        @(negedge Clk);
        Start  = 1'b0;
        busy_n = 0;
        done_n = 0;
        while (Busy && busy_n < 100) begin
            busy_n++;
            if (Done) done_n++;
            if (busy_n == 1) begin
                Start   = 1'b1;
                SrcAddr = 8'h00;
                DstAddr = 8'h70;
                Len     = 9'd3;
            end else begin
                Start = 1'b0;
            end
            @(negedge Clk);
        end
        Start = 1'b0;
        check("mid_start_busy", busy_n, 5);
        check("mid_start_done", done_n, 1);
        n = 0;
        repeat (4) begin
            if (Busy) n++;
            @(negedge Clk);
        end
        check("mid_start_not_queued", n, 0);
        check("mid_start_mem70", mem[8'h70], 8'h70);
        check("mid_start_mem61", mem[8'h61], 8'h11);

        // Reset pulled low during WR.
        load_mem(1'b0);
        @(negedge Clk);
        Start   = 1'b1;
        SrcAddr = 8'h10;
        DstAddr = 8'h40;
        Len     = 9'd4;
        @(negedge Clk);
        Start = 1'b0;
        @(negedge Clk);
        check("rstwr_busy_before", Busy, 1);
        check("rstwr_we_before", MemWriteEn, 1);
        CpuWriteEn = 1'b1;
        CpuAddr    = 8'hC0;
        CpuDataIn  = 8'h5A;
        #2;
        Reset = 1'b0;
        #1;
        check("rstwr_busy", Busy, 0);
        check("rstwr_done", Done, 0);
        check("rstwr_we", MemWriteEn, 1);
        check("rstwr_addr", MemAddr, 8'hC0);
        @(negedge Clk);
        CpuWriteEn = 1'b0;
        Reset      = 1'b1;
        done_n = 0;
        n      = 0;
        repeat (4) begin
            if (Done) done_n++;
            if (Busy) n++;
            @(negedge Clk);
        end
        check("rstwr_no_done", done_n, 0);
        check("rstwr_stays_idle", n, 0);
        check("rstwr_cpu_store", mem[8'hC0], 8'h5A);
        check("rstwr_unwritten", mem[8'h40], 8'h40);

        // Random copies against the memmove model, biased toward overlap.
        for (int it = 0; it < 20; it++) begin
            load_mem(1'b1);
            s = 8'($urandom);
            if ($urandom_range(0, 1) == 1) d = 8'(s + $urandom_range(0, 16) - 8);
            else d = 8'($urandom);
            n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 64));
            do_copy(s, d, 9'(n), busy_n, done_n, we_n, stall_bad);
            model_copy(s, d, n);
            check($sformatf("rnd%0d_busy", it), busy_n, (n == 0 || s == d) ? 1 : 2 * n + 1);
            check($sformatf("rnd%0d_done", it), done_n, 1);
            check($sformatf("rnd%0d_stall", it), stall_bad, 0);
            check_mem($sformatf("rnd%0d_mem", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
